pin_keypad_entry: RTL and testbench

Upstream front-end for the parking controller's PIN check. It converts raw keypad presses into the `pin[7:0]` value and single-cycle `ent_pin` strobe that the controller consumes. Decimal digits accumulate into a binary value of up to three digits. The block also supports clear, enter, idle timeout and error signalling.

---
 rtl/pin_keypad_entry_if.sv | 21 ++
 rtl/pin_keypad_entry.sv | 133 +++++++++++++
 tb/tb_pin_keypad_entry.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/pin_keypad_entry_if.sv
// Keypad-side and PIN-side signal bundle for pin_keypad_entry.
// slave = the entry block, master = whoever drives the keypad and consumes the PIN.
interface pin_keypad_entry_if;
  logic [3:0] key_code;
  logic       key_down;
  logic [7:0] pin;
  logic       ent_pin;
  logic       entry_busy;
  logic [1:0] digit_cnt;
  logic       key_err;

  modport slave (
    input  key_code, key_down,
    output pin, ent_pin, entry_busy, digit_cnt, key_err
  );

  modport master (
    output key_code, key_down,
    input  pin, ent_pin, entry_busy, digit_cnt, key_err
  );
endinterface

// File: rtl/pin_keypad_entry.sv
// Converts keypad presses into a binary PIN (up to three decimal digits) with
// enter/clear handling, an idle timeout and a one-cycle error pulse.
//
// state     | meaning
// S_IDLE    | no digits pending, acc = 0
// S_COLLECT | 1..3 digits pending, idle timer running
module pin_keypad_entry #(
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic              clock,
  input  logic              reset,
  pin_keypad_entry_if.slave kp
);

  localparam int unsigned  TW       = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYC - 1);

  typedef enum logic {S_IDLE, S_COLLECT} state_e;

  state_e        state_q, state_d;
  logic          kd_q, kd_d;
  logic [9:0]    acc_q, acc_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [7:0]    pin_q, pin_d;
  logic          ent_q, ent_d;
  logic          err_q, err_d;

  logic          press;
  logic          is_digit;
  logic [11:0]   acc_next;

  always_comb begin
    press    = kp.key_down & ~kd_q;
    is_digit = (kp.key_code <= 4'd9);
    acc_next = {2'b00, acc_q} * 12'd10 + {8'd0, kp.key_code};

    state_d = state_q;
    kd_d    = kp.key_down;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    pin_d   = pin_q;
    ent_d   = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (press) begin
          if (is_digit) begin
            state_d = S_COLLECT;
            acc_d   = {6'd0, kp.key_code};
            cnt_d   = 2'd1;
            tmr_d   = TMR_LOAD;
          end else if (kp.key_code != 4'd10) begin
            err_d = 1'b1;
          end
        end
      end

      S_COLLECT: begin
        if (press) begin
          // any press, even a rejected one, restarts the idle window
          tmr_d = TMR_LOAD;
          if (is_digit) begin
            if (cnt_q == 2'd3) begin
              err_d = 1'b1;
            end else if (acc_next > 12'd255) begin
              err_d   = 1'b1;
              state_d = S_IDLE;
              acc_d   = '0;
              cnt_d   = '0;
            end else begin
              acc_d = acc_next[9:0];
              cnt_d = cnt_q + 2'd1;
            end
          end else if (kp.key_code == 4'd10) begin
            state_d = S_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
          end else if (kp.key_code == 4'd11) begin
            pin_d   = acc_q[7:0];
            ent_d   = 1'b1;
            state_d = S_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end else if (tmr_q == '0) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // kd_q resets high so a key held through reset release is not a press
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      kd_q    <= 1'b1;
      acc_q   <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      pin_q   <= '0;
      ent_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kd_q    <= kd_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      pin_q   <= pin_d;
      ent_q   <= ent_d;
      err_q   <= err_d;
    end
  end

  assign kp.pin        = pin_q;
  assign kp.ent_pin    = ent_q;
  assign kp.entry_busy = (state_q == S_COLLECT);
  assign kp.digit_cnt  = cnt_q;
  assign kp.key_err    = err_q;

endmodule

// File: tb/tb_pin_keypad_entry.sv
// Directed plus randomized keypad sequences, every cycle compared against a
// behavioural model of digit entry kept as plain integers.
module tb_pin_keypad_entry;
  localparam int T = 20;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  pin_keypad_entry_if bus ();

  pin_keypad_entry #(.TIMEOUT_CYC(T)) dut (
    .clock (clock),
    .reset (reset),
    .kp    (bus.slave)
  );

  always #5 clock = ~clock;

  // reference model: pending entry as an integer value plus digit count
  bit       m_busy;
  int       m_val, m_cnt, m_idle;
  bit       m_prev_kd;
  bit       m_ent, m_err;
  bit [7:0] m_pin;

  task automatic model_clear_entry();
    m_busy = 0; m_val = 0; m_cnt = 0; m_idle = 0;
  endtask

  task automatic model_update(input bit kd, input int code, input bit rst_v);
    int nv;
    if (!rst_v) begin
      model_clear_entry();
      m_prev_kd = 1; m_pin = 0; m_ent = 0; m_err = 0;
      return;
    end
    m_ent = 0; m_err = 0;
    if (kd && !m_prev_kd) begin
      m_idle = 0;
      if (code <= 9) begin
        if (!m_busy) begin
          m_busy = 1; m_val = code; m_cnt = 1;
        end else if (m_cnt == 3) begin
          m_err = 1;
        end else begin
          nv = m_val * 10 + code;
          if (nv > 255) begin
            m_err = 1; model_clear_entry();
          end else begin
            m_val = nv; m_cnt++;
          end
        end
      end else if (code == 10) begin
        model_clear_entry();
      end else if (code == 11) begin
        if (m_busy) begin
          m_pin = 8'(m_val); m_ent = 1; model_clear_entry();
        end else begin
          m_err = 1;
        end
      end else begin
        m_err = 1;
      end
    end else if (m_busy) begin
      m_idle++;
      if (m_idle == T) begin
        m_err = 1; model_clear_entry();
      end
    end
    m_prev_kd = kd;
  endtask

  task automatic check_outputs();
    checks++;
    assert (bus.pin === m_pin) else begin
      failures++; $error("FAIL pin observed=%0d expected=%0d t=%0t", bus.pin, m_pin, $time);
    end
    checks++;
    assert (bus.ent_pin === m_ent) else begin
      failures++; $error("FAIL ent_pin observed=%0b expected=%0b t=%0t", bus.ent_pin, m_ent, $time);
    end
    checks++;
    assert (bus.entry_busy === m_busy) else begin
      failures++; $error("FAIL entry_busy observed=%0b expected=%0b t=%0t", bus.entry_busy, m_busy, $time);
    end
    checks++;
    assert (bus.digit_cnt === 2'(m_cnt)) else begin
      failures++; $error("FAIL digit_cnt observed=%0d expected=%0d t=%0t", bus.digit_cnt, m_cnt, $time);
    end
    checks++;
    assert (bus.key_err === m_err) else begin
      failures++; $error("FAIL key_err observed=%0b expected=%0b t=%0t", bus.key_err, m_err, $time);
    end
  endtask

  task automatic step(input bit kd, input int code, input bit rst_v);
    bus.key_down = kd;
    bus.key_code = 4'(code);
    reset        = rst_v;
    @(posedge clock);
    model_update(kd, code, rst_v);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, $urandom_range(0, 15), 1);
  endtask

  task automatic press(input int code);
    step(1, code, 1);
    step(0, $urandom_range(0, 15), 1);
  endtask

  initial begin
    int r, code, n;
    m_prev_kd = 1; m_pin = 0; m_ent = 0; m_err = 0;
    model_clear_entry();
    bus.key_down = 0;
    bus.key_code = 0;

    step(0, 0, 0);
    step(0, 0, 0);
    idle(2);

    // 7, 2, enter -> 72
    press(7); press(2); press(11); idle(2);
    // 7, 4, clear, 2, 2, enter -> 22
    press(7); press(4); press(10); press(2); press(2); press(11); idle(2);
    // overflow, max value, fourth digit rejected
    press(2); press(5); press(6); idle(1);
    press(2); press(5); press(5); press(11); idle(1);
    press(1); press(2); press(3); press(4); press(11); idle(1);
    // leading zero, lone zero
    press(0); press(7); press(11); press(0); press(11); idle(1);
    press(7); press(2); press(11);
    // enter with nothing pending, invalid code in idle and mid-entry
    press(11); press(13); press(4); press(15); press(11); idle(2);
    // timeout exactly T idle cycles after the press, then press at the last count
    step(1, 7, 1); idle(T + 3);
    step(1, 7, 1); idle(T - 1); step(1, 3, 1); idle(T - 1); press(11);
    // back-to-back presses at minimum spacing
    step(1, 1, 1); step(0, 0, 1); step(1, 9, 1); step(0, 0, 1); step(1, 11, 1); step(0, 0, 1);
    // key held across reset release, then released and pressed again
    step(1, 5, 0); step(1, 5, 1); step(1, 5, 1); step(1, 5, 1); step(0, 5, 1);
    press(5); press(11);
    // reset mid-entry
    press(3); press(4); step(0, 0, 0); idle(2);

    for (int it = 0; it < 500; it++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      press($urandom_range(0, 9));
      else if (r < 70) press(11);
      else if (r < 75) press(10);
      else if (r < 80) press($urandom_range(12, 15));
      else if (r < 87) idle($urandom_range(T - 2, T + 2));
      else if (r < 95) begin
        code = $urandom_range(0, 11);
        n = $urandom_range(2, 5);
        for (int k = 0; k < n; k++) step(1, code, 1);
        step(0, 0, 1);
      end else begin
        step($urandom_range(0, 1), $urandom_range(0, 15), 0);
      end
      idle($urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
